// File: rtl/mmu_access_unit.sv
// Memory-access stage: runs one fetch/load/store at a time on the 64-bit bus.
// Handles alignment checks, byte-lane steering, load sign extension and bus timeouts.
module mmu_access_unit #(
    parameter int ADDR_W         = 36,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clock_enable,
    input  logic              req_valid,
    input  logic [1:0]        req_op,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    output logic              mmu_ready,
    output logic [63:0]       mmu_result_data,
    output logic [15:0]       mmu_result_code,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [63:0]       bus_wdata,
    output logic [7:0]        bus_wstrb,
    input  logic              bus_ack,
    input  logic              bus_err,
    input  logic [63:0]       bus_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUS   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    localparam logic [1:0] OP_FETCH = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b10;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t            r_state;
    state_t            w_state_next;
    logic [1:0]        r_op;
    logic [1:0]        r_size;
    logic              r_signed;
    logic [2:0]        r_lane;
    logic [7:0]        r_count;
    logic [7:0]        w_count_next;
    logic [63:0]       r_result_data;
    logic [63:0]       w_result_data_next;
    logic [15:0]       r_result_code;
    logic [15:0]       w_result_code_next;
    logic              r_bus_req;
    logic              r_bus_we;
    logic [ADDR_W-1:0] r_bus_addr;
    logic [63:0]       r_bus_wdata;
    logic [7:0]        r_bus_wstrb;

    logic              w_accept;
    logic              w_misaligned;
    logic              w_complete;
    logic [1:0]        w_eff_size;
    logic [2:0]        w_lane;
    logic [7:0]        w_size_mask;
    logic [63:0]       w_rshift;
    logic [63:0]       w_load_data;

    function automatic logic [3:0] cause_of(input logic [1:0] op, input logic access_fault);
        case (op)
            OP_FETCH: cause_of = {3'b000, access_fault};
            OP_STORE: cause_of = {3'b011, access_fault};
            default:  cause_of = {3'b010, access_fault};
        endcase
    endfunction

    // NOTE: every signal driven here gets a default before the case, so no latch can be inferred.
    always_comb begin
        w_lane       = req_addr[2:0];
        w_eff_size   = (req_op == OP_FETCH) ? SZ_WORD : req_size;
        w_misaligned = 1'b0;
        w_size_mask  = 8'h01;
        case (w_eff_size)
            SZ_BYTE: begin
                w_misaligned = 1'b0;
                w_size_mask  = 8'h01;
            end
            SZ_HALF: begin
                w_misaligned = w_lane[0];
                w_size_mask  = 8'h03;
            end
            SZ_WORD: begin
                w_misaligned = |w_lane[1:0];
                w_size_mask  = 8'h0F;
            end
            default: begin
                w_misaligned = |w_lane;
                w_size_mask  = 8'hFF;
            end
        endcase
        w_accept = clock_enable && req_valid && (r_state == ST_IDLE);
    end

    // Read data is shifted down so the addressed byte sits in lane 0, then truncated and extended.
    always_comb begin
        w_rshift = bus_rdata >> {r_lane, 3'b000};
        case (r_size)
            SZ_BYTE: w_load_data = {{56{r_signed & w_rshift[7]}},  w_rshift[7:0]};
            SZ_HALF: w_load_data = {{48{r_signed & w_rshift[15]}}, w_rshift[15:0]};
            SZ_WORD: w_load_data = {{32{r_signed & w_rshift[31]}}, w_rshift[31:0]};
            default: w_load_data = w_rshift;
        endcase
    end

    always_comb begin
        w_state_next       = r_state;
        w_complete         = 1'b0;
        w_count_next       = r_count;
        w_result_data_next = r_result_data;
        w_result_code_next = r_result_code;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_state_next = w_misaligned ? ST_FAULT : ST_BUS;
                end
            end
            ST_BUS: begin
                w_count_next = r_count + 8'd1;
                if (bus_err) begin
                    w_complete         = 1'b1;
                    w_result_data_next = 64'h0;
                    w_result_code_next = {12'h800, cause_of(r_op, 1'b1)};
                end else if (bus_ack) begin
                    w_complete         = 1'b1;
                    w_result_code_next = 16'h0000;
                    if (r_op == OP_FETCH) begin
                        w_result_data_next = {w_rshift[31:0], 32'h0};
                    end else if (r_op == OP_STORE) begin
                        w_result_data_next = 64'h0;
                    end else begin
                        w_result_data_next = w_load_data;
                    end
                end else if (r_count == TIMEOUT_LAST) begin
                    w_complete         = 1'b1;
                    w_result_data_next = 64'h0;
                    w_result_code_next = {12'h800, cause_of(r_op, 1'b1)};
                end
                if (w_complete) begin
                    w_state_next = ST_IDLE;
                    w_count_next = 8'd0;
                end
            end
            ST_FAULT: begin
                w_complete         = 1'b1;
                w_state_next       = ST_IDLE;
                w_result_data_next = 64'h0;
                w_result_code_next = {12'h800, cause_of(r_op, 1'b0)};
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else if (clock_enable) begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_op          <= 2'b00;
            r_size        <= 2'b00;
            r_signed      <= 1'b0;
            r_lane        <= 3'd0;
            r_count       <= 8'd0;
            r_result_data <= 64'h0;
            r_result_code <= 16'h0;
            r_bus_req     <= 1'b0;
            r_bus_we      <= 1'b0;
            r_bus_addr    <= '0;
            r_bus_wdata   <= 64'h0;
            r_bus_wstrb   <= 8'h0;
        end else if (clock_enable) begin
            r_count       <= w_count_next;
            r_result_data <= w_result_data_next;
            r_result_code <= w_result_code_next;
            if (w_accept) begin
                r_op     <= req_op;
                r_size   <= w_eff_size;
                r_signed <= req_signed;
                r_lane   <= w_lane;
            end
            // Bus fields are launched only for aligned requests and then held until the next launch.
            if (w_accept && !w_misaligned) begin
                r_bus_req  <= 1'b1;
                r_bus_we   <= (req_op == OP_STORE);
                r_bus_addr <= {req_addr[ADDR_W-1:3], 3'b000};
                if (req_op == OP_STORE) begin
                    r_bus_wdata <= req_wdata << {w_lane, 3'b000};
                    r_bus_wstrb <= w_size_mask << w_lane;
                end else begin
                    r_bus_wdata <= 64'h0;
                    r_bus_wstrb <= 8'h0;
                end
            end else if (w_complete) begin
                r_bus_req <= 1'b0;
            end
        end
    end

    assign mmu_ready       = (r_state == ST_IDLE);
    assign mmu_result_data = r_result_data;
    assign mmu_result_code = r_result_code;
    assign bus_req         = r_bus_req;
    assign bus_we          = r_bus_we;
    assign bus_addr        = r_bus_addr;
    assign bus_wdata       = r_bus_wdata;
    assign bus_wstrb       = r_bus_wstrb;

endmodule

// File: tb/tb_mmu_access_unit.sv
// Self-checking bench for mmu_access_unit: a transaction-level model plus
// hand-computed literals, with a per-cycle compare of ready/bus_req/results.
module tb_mmu_access_unit;

    localparam int ADDR_W = 36;
    localparam int TMO    = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic              clock_enable;
    logic              req_valid;
    logic [1:0]        req_op;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [63:0]       req_wdata;
    logic              mmu_ready;
    logic [63:0]       mmu_result_data;
    logic [15:0]       mmu_result_code;
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [63:0]       bus_wdata;
    logic [7:0]        bus_wstrb;
    logic              bus_ack;
    logic              bus_err;
    logic [63:0]       bus_rdata;

    int n_checks = 0;
    int n_errors = 0;

    logic        cmp_en = 1'b0;
    logic        exp_ready;
    logic        exp_bus_req;
    logic [63:0] exp_data;
    logic [15:0] exp_code;

    mmu_access_unit #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO)) dut (
        .clock           (clock),
        .reset           (reset),
        .clock_enable    (clock_enable),
        .req_valid       (req_valid),
        .req_op          (req_op),
        .req_size        (req_size),
        .req_signed      (req_signed),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .mmu_ready       (mmu_ready),
        .mmu_result_data (mmu_result_data),
        .mmu_result_code (mmu_result_code),
        .bus_req         (bus_req),
        .bus_we          (bus_we),
        .bus_addr        (bus_addr),
        .bus_wdata       (bus_wdata),
        .bus_wstrb       (bus_wstrb),
        .bus_ack         (bus_ack),
        .bus_err         (bus_err),
        .bus_rdata       (bus_rdata)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Expected outcome of one request, derived byte by byte from the access rules.
    function automatic void model(input logic [1:0] op, input logic [1:0] size, input logic sgn,
                                  input logic [ADDR_W-1:0] addr, input logic [63:0] wdata,
                                  input logic [63:0] rdata, input logic bus_fault,
                                  output logic mis, output logic [63:0] data,
                                  output logic [15:0] code, output logic [7:0] strb,
                                  output logic [63:0] bw);
        int          nbytes;
        int          lane;
        int          base;
        logic [63:0] val;
        nbytes = (op == 2'b00) ? 4 : (1 << size);
        lane   = int'(addr % 36'd8);
        mis    = (lane % nbytes) != 0;
        base   = (op == 2'b00) ? 0 : (op == 2'b10) ? 6 : 4;
        strb   = 8'h00;
        val    = 64'h0;
        bw     = wdata << (8 * lane);
        for (int i = 0; i < nbytes; i++) begin
            if (lane + i < 8) begin
                strb[lane + i]   = 1'b1;
                val[8 * i +: 8]  = rdata[8 * (lane + i) +: 8];
            end
        end
        if (op != 2'b00 && op != 2'b10 && sgn && nbytes < 8 && val[8 * nbytes - 1]) begin
            for (int i = nbytes; i < 8; i++) val[8 * i +: 8] = 8'hFF;
        end
        if (mis) begin
            data = 64'h0;
            code = 16'h8000 | 16'(base);
        end else if (bus_fault) begin
            data = 64'h0;
            code = 16'h8000 | 16'(base + 1);
        end else begin
            code = 16'h0000;
            if (op == 2'b00)      data = val << 32;
            else if (op == 2'b10) data = 64'h0;
            else                  data = val;
        end
    endfunction

    // Runs one request; ack_at counts enabled BUS cycles before the target responds.
    task automatic do_req(input logic [1:0] op, input logic [1:0] size, input logic sgn,
                          input logic [ADDR_W-1:0] addr, input logic [63:0] wdata,
                          input logic give_ack, input int ack_at, input logic err,
                          input logic [63:0] rdata, input int stall_at, input int stall_len);
        logic        mis;
        logic [63:0] m_data;
        logic [63:0] m_bw;
        logic [15:0] m_code;
        logic [7:0]  m_strb;
        int          n;
        bit          done;
        model(op, size, sgn, addr, wdata, rdata, !give_ack || err, mis, m_data, m_code, m_strb, m_bw);
        req_op     = op;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        req_valid  = 1'b1;
        tick();
        req_valid   = 1'b0;
        exp_ready   = 1'b0;
        exp_bus_req = !mis;
        if (mis) begin
            tick();
        end else begin
            check("bus_addr", 64'(bus_addr), 64'(addr - (addr % 36'd8)));
            check("bus_we", 64'(bus_we), 64'(op == 2'b10));
            if (op == 2'b10) begin
                check("bus_wstrb", 64'(bus_wstrb), 64'(m_strb));
                check("bus_wdata", bus_wdata, m_bw);
            end
            n    = 0;
            done = 0;
            while (!done) begin
                if (give_ack && n == ack_at) begin
                    bus_ack   = 1'b1;
                    bus_err   = err;
                    bus_rdata = rdata;
                end
                if (n == stall_at) begin
                    clock_enable = 1'b0;
                    repeat (stall_len) tick();
                    clock_enable = 1'b1;
                end
                tick();
                if (bus_ack) done = 1;
                n++;
                if (!give_ack && n == TMO) done = 1;
                if (n > 50) begin
                    check("bus_loop_bound", 64'(n), 64'(0));
                    done = 1;
                end
            end
            bus_ack = 1'b0;
            bus_err = 1'b0;
        end
        exp_ready   = 1'b1;
        exp_bus_req = 1'b0;
        exp_data    = m_data;
        exp_code    = m_code;
    endtask

    always @(negedge clock) begin
        if (cmp_en && !reset) begin
            check("mmu_ready", 64'(mmu_ready), 64'(exp_ready));
            check("bus_req", 64'(bus_req), 64'(exp_bus_req));
            if (exp_ready) begin
                check("result_data", mmu_result_data, exp_data);
                check("result_code", 64'(mmu_result_code), 64'(exp_code));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset        = 1'b1;
        clock_enable = 1'b1;
        req_valid    = 1'b0;
        req_op       = 2'b00;
        req_size     = 2'b00;
        req_signed   = 1'b0;
        req_addr     = '0;
        req_wdata    = 64'h0;
        bus_ack      = 1'b0;
        bus_err      = 1'b0;
        bus_rdata    = 64'h0;
        #12;
        check("rst_ready", 64'(mmu_ready), 64'd1);
        check("rst_data", mmu_result_data, 64'h0);
        check("rst_code", 64'(mmu_result_code), 64'h0);
        check("rst_bus_req", 64'(bus_req), 64'd0);
        check("rst_bus_we", 64'(bus_we), 64'd0);
        check("rst_bus_addr", 64'(bus_addr), 64'd0);
        check("rst_bus_wdata", bus_wdata, 64'h0);
        check("rst_bus_wstrb", 64'(bus_wstrb), 64'h0);
        reset = 1'b0;
        tick();
        exp_ready   = 1'b1;
        exp_bus_req = 1'b0;
        exp_data    = 64'h0;
        exp_code    = 16'h0;
        cmp_en      = 1'b1;

        // Fetch, ack in the first BUS cycle
        do_req(2'b00, 2'b11, 1'b0, 36'h4_0000_0000, 64'h0, 1'b1, 0, 1'b0,
               64'h1111_2222_0000_0013, -1, 0);
        check("lit_fetch_data", mmu_result_data, 64'h0000_0013_0000_0000);
        check("lit_fetch_code", 64'(mmu_result_code), 64'h0);

        // Byte load from lane 5, signed then unsigned
        do_req(2'b01, 2'b00, 1'b1, 36'h1_2345_6785, 64'h0, 1'b1, 1, 1'b0,
               64'hAA11_80CC_DDEE_FF77, -1, 0);
        check("lit_sbyte", mmu_result_data, 64'hFFFF_FFFF_FFFF_FF80);
        do_req(2'b01, 2'b00, 1'b0, 36'h1_2345_6785, 64'h0, 1'b1, 0, 1'b0,
               64'hAA11_80CC_DDEE_FF77, -1, 0);
        check("lit_ubyte", mmu_result_data, 64'h0000_0000_0000_0080);

        // Half store to lane 6
        do_req(2'b10, 2'b01, 1'b0, 36'h0_0000_1006, 64'h0000_0000_0000_BEEF, 1'b1, 1, 1'b0,
               64'h0, -1, 0);
        check("lit_hstore_strb", 64'(bus_wstrb), 64'hC0);
        check("lit_hstore_wdata", 64'(bus_wdata[63:48]), 64'hBEEF);
        check("lit_hstore_we", 64'(bus_we), 64'd1);
        check("lit_hstore_code", 64'(mmu_result_code), 64'h0);

        // Misaligned word load and misaligned fetch
        do_req(2'b01, 2'b10, 1'b0, 36'h0_0000_2002, 64'h0, 1'b1, 0, 1'b0, 64'h0, -1, 0);
        check("lit_mis_load", 64'(mmu_result_code), 64'h8004);
        do_req(2'b00, 2'b00, 1'b0, 36'h0_0000_2006, 64'h0, 1'b1, 0, 1'b0, 64'h0, -1, 0);
        check("lit_mis_fetch", 64'(mmu_result_code), 64'h8000);

        // Store with bus_err and bus_ack together
        do_req(2'b10, 2'b11, 1'b0, 36'h0_0000_3008, 64'h0123_4567_89AB_CDEF, 1'b1, 0, 1'b1,
               64'hFFFF_FFFF_FFFF_FFFF, -1, 0);
        check("lit_store_err", 64'(mmu_result_code), 64'h8007);
        check("lit_store_err_data", mmu_result_data, 64'h0);

        // Load timeout followed by a stray ack while idle
        do_req(2'b01, 2'b10, 1'b0, 36'h0_0000_4010, 64'h0, 1'b0, 0, 1'b0, 64'h0, -1, 0);
        check("lit_timeout", 64'(mmu_result_code), 64'h8005);
        bus_ack   = 1'b1;
        bus_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        tick();
        tick();
        bus_ack = 1'b0;
        check("stray_ack_code", 64'(mmu_result_code), 64'h8005);
        check("stray_ack_bus_req", 64'(bus_req), 64'd0);

        // Further lane/size patterns
        do_req(2'b01, 2'b11, 1'b1, 36'h0_0000_5018, 64'h0, 1'b1, 2, 1'b0,
               64'h8123_4567_89AB_CDEF, -1, 0);
        check("lit_dword", mmu_result_data, 64'h8123_4567_89AB_CDEF);
        do_req(2'b01, 2'b01, 1'b0, 36'h0_0000_500A, 64'h0, 1'b1, 0, 1'b0,
               64'hFFFF_FFFF_9876_FFFF, -1, 0);
        check("lit_uhalf", mmu_result_data, 64'h0000_0000_0000_9876);
        do_req(2'b10, 2'b00, 1'b0, 36'h0_0000_6003, 64'h0000_0000_0000_005A, 1'b1, 0, 1'b0,
               64'h0, -1, 0);
        check("lit_bstore_strb", 64'(bus_wstrb), 64'h08);
        check("lit_bstore_wdata", bus_wdata, 64'h0000_0000_5A00_0000);
        do_req(2'b11, 2'b01, 1'b1, 36'h0_0000_7004, 64'h0, 1'b1, 0, 1'b0,
               64'h1234_F00D_5678_9ABC, -1, 0);
        check("lit_rsvd_load", mmu_result_data, 64'hFFFF_FFFF_FFFF_F00D);
        do_req(2'b11, 2'b01, 1'b0, 36'h0_0000_7001, 64'h0, 1'b1, 0, 1'b0, 64'h0, -1, 0);
        check("lit_rsvd_mis", 64'(mmu_result_code), 64'h8004);

        // Stall with ack pending, then stall in the middle of a timeout
        do_req(2'b01, 2'b10, 1'b1, 36'h0_0000_8004, 64'h0, 1'b1, 0, 1'b0,
               64'h8765_4321_0000_0000, 0, 3);
        check("lit_stall_word", mmu_result_data, 64'hFFFF_FFFF_8765_4321);
        do_req(2'b01, 2'b01, 1'b0, 36'h0_0000_8002, 64'h0, 1'b0, 0, 1'b0, 64'h0, 2, 3);
        check("lit_stall_timeout", 64'(mmu_result_code), 64'h8005);

        // Asynchronous reset in the middle of a bus transaction
        req_op    = 2'b01;
        req_size  = 2'b10;
        req_addr  = 36'h0_0000_0020;
        req_valid = 1'b1;
        tick();
        req_valid   = 1'b0;
        exp_ready   = 1'b0;
        exp_bus_req = 1'b1;
        tick();
        #2;
        reset       = 1'b1;
        exp_ready   = 1'b1;
        exp_bus_req = 1'b0;
        exp_data    = 64'h0;
        exp_code    = 16'h0;
        #1;
        check("arst_bus_req", 64'(bus_req), 64'd0);
        check("arst_ready", 64'(mmu_ready), 64'd1);
        check("arst_code", 64'(mmu_result_code), 64'h0);
        check("arst_data", mmu_result_data, 64'h0);
        tick();
        reset = 1'b0;
        tick();

        do_req(2'b00, 2'b00, 1'b0, 36'h0_0000_9004, 64'h0, 1'b1, 1, 1'b0,
               64'hCAFE_F00D_1234_5678, -1, 0);
        check("lit_fetch_hi", mmu_result_data, 64'hCAFE_F00D_0000_0000);

        tick();
        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mmu_access_unit.md
Name: mmu_access_unit

Overview:
- Memory-access stage directly upstream of the instruction-sequencing FSM.
- Accepts one fetch, load or store request at a time and runs it on the 64-bit system bus.
- Returns result data plus a 16-bit status code on mmu_result_data / mmu_result_code, with mmu_ready as the completion and idle indicator.
- Checks alignment, steers byte lanes, sign-extends loads, and times out unresponsive bus targets.

Parameters:
ADDR_W, 36, physical address width
TIMEOUT_CYCLES, 255, maximum cycles bus_req may stay high without bus_ack/bus_err (1..255)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
clock_enable  in  1  global stall; when low all state, counters and outputs hold
req_valid  in  1  request present
req_op  in  2  00 fetch, 01 load, 10 store, 11 reserved (treated as load)
req_size  in  2  00 byte, 01 half, 10 word, 11 dword (fetch forces word)
req_signed  in  1  sign-extend load result
req_addr  in  ADDR_W  byte address
req_wdata  in  64  store data, right-aligned
mmu_ready  out  1  unit idle; mmu_result_* hold the last completed request
mmu_result_data  out  64  result data
mmu_result_code  out  16  status: bit15 error, bits3:0 cause, others 0
bus_req  out  1  bus transaction request
bus_we  out  1  write
bus_addr  out  ADDR_W  dword-aligned address (addr[2:0]=0)
bus_wdata  out  64  lane-positioned write data
bus_wstrb  out  8  byte enables
bus_ack  in  1  transaction complete, bus_rdata valid
bus_err  in  1  transaction failed (takes priority over bus_ack)
bus_rdata  in  64  read data, little-endian

Behaviour:
- Reset values:
  - State IDLE, mmu_ready=1.
  - mmu_result_data=0, mmu_result_code=0.
  - bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_wstrb=0.
  - Timeout counter 0.
  - Reset mid-transaction drops bus_req immediately and discards the request.
- Accept: request is accepted on the rising edge where clock_enable && req_valid && mmu_ready. Request fields are captured. The requester must hold fields until accept.
- States:
  - IDLE: mmu_ready=1.
    - Aligned accept -> BUS.
    - Misaligned accept -> FAULT.
  - BUS: bus_req=1, other bus outputs stable, mmu_ready=0. Counter increments each enabled cycle.
    - bus_err -> IDLE with access-fault code.
    - Else bus_ack -> IDLE with data, code 0.
    - Else counter reaches TIMEOUT_CYCLES -> IDLE with access-fault code. bus_req drops, and a late ack is ignored.
  - FAULT: one cycle, mmu_ready=0, no bus activity -> IDLE with misaligned code.
- Alignment: misaligned when addr mod size != 0. Sizes are 1, 2, 4, 8 bytes; fetch always uses size 4.
- Cause codes (code = 16'h8000 | cause on error):
  - fetch: misaligned 0, access fault 1
  - load: misaligned 4, access fault 5
  - store: misaligned 6, access fault 7
  - Success code = 16'h0000.
- On error, mmu_result_data = 0.
- Latency:
  - Aligned access: result registered and mmu_ready=1 on the same edge that samples bus_ack. Minimum accept-to-ready is 2 cycles when ack is in the first BUS cycle.
  - Misaligned access: mmu_ready=1 exactly 2 edges after accept.
- Lane steering: lane = addr[2:0].
  - Store: bus_wdata = req_wdata << (8*lane). bus_wstrb = size mask (01, 03, 0F, FF) << lane.
  - Load: bytes extracted from bus_rdata >> (8*lane), truncated to size, then zero- or sign-extended to 64 bits. dword ignores req_signed.
  - Fetch: mmu_result_data[63:32] = 32-bit word at addr, [31:0] = 0.
  - Store success returns mmu_result_data = 0.
- clock_enable low: no transitions, counter frozen, bus outputs hold. A bus_ack arriving while disabled is not sampled; the bus target holds ack until sampled.
- Outputs: mmu_result_* change only on completion edges and are stable while mmu_ready=1.

Test Plan:
- Fetch addr 0x4_0000_0000, bus_ack next cycle with rdata 0x1111_2222_0000_0013 -> mmu_result_data 0x0000_0013_0000_0000, code 0x0000, mmu_ready low exactly 1 cycle.
- Signed byte load addr 0x...5, rdata byte5=0x80 -> data 0xFFFF_FFFF_FFFF_FF80; same with req_signed=0 -> 0x80.
- Half store addr 0x...6, wdata 0xBEEF -> bus_wstrb 0xC0, bus_wdata[63:48]=0xBEEF, bus_we=1, code 0x0000.
- Word load addr 0x...2 -> no bus_req, code 0x8004, mmu_ready high 2 edges after accept; misaligned fetch -> 0x8000.
- bus_err with ack on store -> code 0x8007. No ack for TIMEOUT_CYCLES=4 -> bus_req drops after 4 cycles, code 0x8005 (load); later stray ack ignored.
- Assert reset during BUS -> bus_req 0 asynchronously, mmu_ready 1, results 0. Hold clock_enable low for 3 cycles mid-BUS -> counter and outputs frozen, completion delayed by 3 cycles.
